seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode/cathode 7-seg display.

---
 rtl/seg7_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display sharing one decoder.
// Double-buffered value (shadow -> display at frame boundary), blank gaps, leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_blank_lz,
    output logic                  o_ready,
    output logic [3:0]            o_nibble,
    output logic [N_DIGITS-1:0]   o_digit_en,
    output logic                  o_blank,
    output logic                  o_frame
);

    localparam int MAX_DIV = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d;
    logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    ready_d;
    logic [3:0]              nibble_d;
    logic [N_DIGITS-1:0]     digit_en_d;
    logic                    blank_d;
    logic                    boundary;
    logic                    commit;
    logic                    suppress;
    logic [N_DIGITS-1:0]     nonzero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            o_ready    <= 1'b1;
            o_nibble   <= '0;
            o_digit_en <= '0;
            o_blank    <= 1'b1;
            o_frame    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            o_ready    <= ready_d;
            o_nibble   <= nibble_d;
            o_digit_en <= digit_en_d;
            o_blank    <= blank_d;
            o_frame    <= boundary;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d  = S_BLANK;
                    idx_d    = '0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Disable overrides any transition, including a pending frame boundary.
        if (!i_enable) begin
            state_d  = S_IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b0;
        end

        commit    = pending_q && ((state_q == S_IDLE) || boundary);
        disp_d    = commit ? shadow_q : disp_q;
        shadow_d  = shadow_q;
        pending_d = commit ? 1'b0 : pending_q;
        if (i_load && !pending_q) begin
            shadow_d  = i_value;
            pending_d = 1'b1;
        end
        ready_d = !pending_d;

        // Nibble latched on slot entry from the value that will be displayed this frame.
        nibble_d = o_nibble;
        if (state_d == S_IDLE) begin
            nibble_d = '0;
        end else if ((state_d == S_BLANK) && (state_q != S_BLANK)) begin
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                if (idx_d == IW'(k)) begin
                    nibble_d = disp_d[4*k +: 4];
                end
            end
        end

        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            nonzero[k] = |disp_q[4*k +: 4];
        end
        suppress = i_blank_lz && (idx_d != '0) && ((nonzero >> idx_d) == '0);

        digit_en_d = '0;
        blank_d    = 1'b1;
        if ((state_d == S_ON) && !suppress) begin
            digit_en_d = N_DIGITS'(1) << idx_d;
            blank_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized + directed bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 1;
    localparam int SLOT  = B + R;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_enable = 1'b0;
    logic           i_load = 1'b0;
    logic [4*N-1:0] i_value = '0;
    logic           i_blank_lz = 1'b0;
    logic           o_ready;
    logic [3:0]     o_nibble;
    logic [N-1:0]   o_digit_en;
    logic           o_blank;
    logic           o_frame;

    seg7_scan_ctrl #(
        .N_DIGITS(N),
        .REFRESH_DIV(R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_enable(i_enable),
        .i_load(i_load),
        .i_value(i_value),
        .i_blank_lz(i_blank_lz),
        .o_ready(o_ready),
        .o_nibble(o_nibble),
        .o_digit_en(o_digit_en),
        .o_blank(o_blank),
        .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: running flag plus absolute position within the frame.
    bit             m_run = 0;
    int             m_pos = 0;
    logic [4*N-1:0] m_disp = '0;
    logic [4*N-1:0] m_shadow = '0;
    bit             m_pend = 0;
    bit             m_lz = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    endtask

    function automatic void model_clk();
        bit commit;
        bit accept;
        if (rst) begin
            m_run = 0; m_pos = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_lz = 0;
            return;
        end
        accept = i_load && !m_pend;
        commit = 0;
        if (!i_enable) begin
            commit = m_pend && !m_run;
            m_run = 0;
            m_pos = 0;
        end else if (!m_run) begin
            commit = m_pend;
            m_run = 1;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            commit = m_pend && (m_pos == 0);
        end
        if (commit) begin
            m_disp = m_shadow;
            m_pend = 0;
        end
        if (accept) begin
            m_shadow = i_value;
            m_pend = 1;
        end
        m_lz = i_blank_lz;
    endfunction

    task automatic compare();
        int digit;
        bit lit;
        bit supp;
        logic [4*N-1:0] upper;
        logic [31:0] e_nib, e_en;
        digit = m_pos / SLOT;
        upper = m_disp >> (4 * digit);
        supp  = (digit > 0) && m_lz && (upper == '0);
        lit   = m_run && ((m_pos % SLOT) >= B) && !supp;
        e_nib = m_run ? 32'(upper[3:0]) : 32'd0;
        e_en  = lit ? (32'd1 << digit) : 32'd0;
        check("ready",    32'(o_ready),    32'(!m_pend));
        check("nibble",   32'(o_nibble),   e_nib);
        check("digit_en", 32'(o_digit_en), e_en);
        check("blank",    32'(o_blank),    32'(!lit));
        check("frame",    32'(o_frame),    32'(m_run && (m_pos == 0)));
        check("onehot",   32'($countones(o_digit_en) <= 1), 32'd1);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_clk();
            #1;
            compare();
        end
    endtask

    task automatic load(input logic [4*N-1:0] v);
        i_load = 1'b1;
        i_value = v;
        tick();
        i_load = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_value();
        logic [4*N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 2) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        // 1: reset held, then mid-scan reset.
        tick(3);
        rst = 1'b0;
        load(16'h7777);
        i_enable = 1'b1;
        tick(27);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        i_enable = 1'b0;
        tick(2);

        // 2: load in idle, then enable and scan two frames.
        load(16'h1234);
        tick(2);
        i_enable = 1'b1;
        tick(2 * FRAME);

        // 3: load during digit 1, second load ignored while not ready.
        tick(SLOT + 2);
        load(16'hABCD);
        load(16'h5555);
        tick(2 * FRAME);

        // 4: leading-zero blanking.
        i_blank_lz = 1'b1;
        load(16'h0050);
        tick(2 * FRAME);
        load(16'h0000);
        tick(2 * FRAME);
        i_blank_lz = 1'b0;
        tick(FRAME);

        // 5: drop enable during digit 2 ON, then re-enable.
        load(16'h9876);
        tick(FRAME);
        while (!(o_digit_en[2])) tick();
        i_enable = 1'b0;
        tick(3);
        i_enable = 1'b1;
        tick(FRAME + 3);

        // 6: reset with a load pending.
        load(16'hFEED);
        check("pending_before_rst", 32'(o_ready), 32'd0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(FRAME);

        // Random phase.
        for (int c = 0; c < 2500; c++) begin
            i_load = ($urandom_range(0, 7) == 0);
            if (i_load) i_value = rand_value();
            if ($urandom_range(0, 59) == 0) i_enable = ~i_enable;
            if ($urandom_range(0, 29) == 0) i_blank_lz = ~i_blank_lz;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
